// File: rtl/sqrt_pkg.sv
// Shared definitions for the RAM-walking square-root sequencer:
// default widths, the FSM state encoding and the timeout fill word.
package sqrt_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int ROOT_W = 4;

    // Word written back when the root unit fails to answer in time.
    localparam logic [DATA_W-1:0] FF_FILL = {DATA_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LD   = 3'd2,
        ST_GO   = 3'd3,
        ST_WAIT = 3'd4,
        ST_WR   = 3'd5,
        ST_FIN  = 3'd6
    } state_t;

endpackage

// File: rtl/sqrt_wait_timer.sv
// Saturating cycle counter that bounds how long the sequencer waits for
// the square-root unit. Cleared before WAIT, counts while enabled, and
// flags expiry once it reaches TIMEOUT-1.
module sqrt_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count up while enabled, holding at LIMIT; clear has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/sqrt_mem_sequencer.sv
// Walks addresses 0..N_WORDS-1 of a synchronous RAM, feeds each word to an
// iterative square-root unit via a start/done handshake and writes the
// zero-extended root back in place. A watchdog turns a missing answer
// into an all-ones word plus a sticky error flag.
module sqrt_mem_sequencer
    import sqrt_pkg::*;
#(
    parameter int ADDR_W  = sqrt_pkg::ADDR_W,
    parameter int DATA_W  = sqrt_pkg::DATA_W,
    parameter int ROOT_W  = sqrt_pkg::ROOT_W,
    parameter int N_WORDS = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              ResetN,
    input  logic              St,
    output logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] MDO,
    output logic [DATA_W-1:0] MDI,
    output logic              Write_Enable,
    output logic [DATA_W-1:0] Root_N,
    output logic              Root_St,
    input  logic [ROOT_W-1:0] Root_Q,
    input  logic              Root_Done,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] mdi_q;
    logic [DATA_W-1:0] root_n_q;
    logic              we_q;
    logic              root_st_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              root_done_prev_q;

    logic              done_edge;
    logic              expired;

    // A level left high from an earlier word must not complete a new one,
    // so only a fresh 0->1 transition counts.
    assign done_edge = Root_Done & ~root_done_prev_q;

    sqrt_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (CLK),
        .rst_ni    (ResetN),
        .clr_i     (state_q == ST_GO),
        .en_i      (state_q == ST_WAIT),
        .expired_o (expired)
    );

    // Remember the previous Root_Done level for edge detection.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            root_done_prev_q <= 1'b0;
        end else begin
            root_done_prev_q <= Root_Done;
        end
    end

    // Main sequencer: state, address walk, data capture and registered strobes.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            mdi_q     <= '0;
            root_n_q  <= '0;
            we_q      <= 1'b0;
            root_st_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a transition re-asserts them.
            we_q      <= 1'b0;
            root_st_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (St) begin
                        state_q <= ST_RD;
                        addr_q  <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RD: begin
                    state_q <= ST_LD;
                end
                ST_LD: begin
                    root_n_q  <= MDO;
                    root_st_q <= 1'b1;
                    state_q   <= ST_GO;
                end
                ST_GO: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the expiry cycle still counts as success.
                    if (done_edge) begin
                        mdi_q   <= DATA_W'(Root_Q);
                        we_q    <= 1'b1;
                        state_q <= ST_WR;
                    end else if (expired) begin
                        mdi_q   <= FF_FILL;
                        err_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (addr_q == LAST_ADDR) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= ST_RD;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Addr         = addr_q;
    assign MDI          = mdi_q;
    assign Write_Enable = we_q;
    assign Root_N       = root_n_q;
    assign Root_St      = root_st_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Err          = err_q;

endmodule

// File: tb/tb_sqrt_mem_sequencer.sv
// Directed bench for sqrt_mem_sequencer with a behavioural synchronous RAM,
// a behavioural square-root unit and a write-back scoreboard.
module tb_sqrt_mem_sequencer;

    logic       CLK;
    logic       ResetN;
    logic       St;
    logic [3:0] Addr;
    logic [7:0] MDO;
    logic [7:0] MDI;
    logic       Write_Enable;
    logic [7:0] Root_N;
    logic       Root_St;
    logic [3:0] Root_Q;
    logic       Root_Done;
    logic       Busy;
    logic       Done;
    logic       Err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Bench-side model state
    logic [7:0]  ram [16];
    logic [7:0]  exp_mem [16];
    logic [11:0] exp_q [$];
    logic [7:0]  init_tbl [16] = '{8'd1, 8'd4, 8'd9, 8'd16, 8'd25, 8'd36, 8'd49, 8'd64,
                                   8'd0, 8'd6, 8'd13, 8'd21, 8'd27, 8'd44, 8'd225, 8'd255};
    logic       ld_en   = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    int         hang_addr = -1;
    bit         hold_high = 1'b0;

    sqrt_mem_sequencer #(
        .ADDR_W  (4),
        .DATA_W  (8),
        .ROOT_W  (4),
        .N_WORDS (16),
        .TIMEOUT (64)
    ) dut (
        .CLK          (CLK),
        .ResetN       (ResetN),
        .St           (St),
        .Addr         (Addr),
        .MDO          (MDO),
        .MDI          (MDI),
        .Write_Enable (Write_Enable),
        .Root_N       (Root_N),
        .Root_St      (Root_St),
        .Root_Q       (Root_Q),
        .Root_Done    (Root_Done),
        .Busy         (Busy),
        .Done         (Done),
        .Err          (Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous RAM with a bench preload port
    always @(posedge CLK) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (Write_Enable) ram[Addr] <= MDI;
        MDO <= ram[Addr];
    end

    function automatic logic [3:0] isqrt(input logic [7:0] x);
        for (int r = 15; r >= 0; r--) begin
            if (r * r <= int'(x)) return 4'(r);
        end
        return 4'd0;
    endfunction

    // Behavioural root unit: answers in the 3rd WAIT cycle, then drops Done
    initial begin
        logic [3:0] r;
        Root_Done = 1'b0;
        Root_Q    = 4'd0;
        forever begin
            @(posedge CLK); #1;
            if (Root_St && !hold_high && (int'(Addr) != hang_addr)) begin
                r = isqrt(Root_N);
                repeat (3) @(posedge CLK);
                #1;
                Root_Q    = r;
                Root_Done = 1'b1;
                @(posedge CLK); #1;
                Root_Done = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            ld_en      = 1'b1;
            ld_addr    = 4'(i);
            ld_data    = init_tbl[i];
            exp_mem[i] = init_tbl[i];
            @(posedge CLK); #1;
        end
        ld_en = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Push the expected write-back for addresses 0..n-1 and update the shadow
    task automatic push_expect(input int n);
        logic [7:0] e;
        for (int a = 0; a < n; a++) begin
            e = (hold_high || a == hang_addr) ? sqrt_pkg::FF_FILL : {4'd0, isqrt(exp_mem[a])};
            exp_q.push_back({4'(a), e});
            exp_mem[a] = e;
        end
    endtask

    task automatic check_write();
        logic [11:0] e;
        chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("write addr=%0d data=%02h expected addr=%0d data=%02h", Addr, MDI, e[11:8], e[7:0]);
            chk("wr_addr", 32'(Addr), 32'(e[11:8]));
            chk("wr_data", 32'(MDI), 32'(e[7:0]));
        end
    endtask

    task automatic run_pass(input int lat, input bit pulse, input int bound);
        int cyc   = 0;
        int dones = 0;
        int first = 0;
        push_expect(16);
        St = 1'b1;
        while (cyc < bound) begin
            @(posedge CLK); #1;
            cyc++;
            if (cyc == 1) begin
                St = 1'b0;
                chk("accept_busy", 32'(Busy), 32'd1);
                chk("accept_err_clear", 32'(Err), 32'd0);
            end
            if (pulse && cyc == 25) St = 1'b1;
            if (pulse && cyc == 26) St = 1'b0;
            if (Write_Enable) check_write();
            if (Done) begin
                dones++;
                if (dones == 1) first = cyc;
            end
            if (dones > 0 && !Busy) break;
        end
        chk("pass_within_bound", 32'(cyc < bound), 32'd1);
        chk("pass_latency", 32'(first), 32'(lat));
        chk("done_pulse_count", 32'(dones), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        for (int a = 0; a < 16; a++) chk("ram_word", 32'(ram[a]), 32'(exp_mem[a]));
    endtask

    initial begin
        logic [7:0] w;
        int  cyc;
        bit  hit;
        ResetN = 1'b0;
        St     = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_addr", 32'(Addr), 32'd0);
        chk("rst_mdi", 32'(MDI), 32'd0);
        chk("rst_we", 32'(Write_Enable), 32'd0);
        chk("rst_root_n", 32'(Root_N), 32'd0);
        chk("rst_root_st", 32'(Root_St), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        @(negedge CLK);
        ResetN = 1'b1;
        @(posedge CLK); #1;

        // Full pass with a prompt root unit
        preload();
        run_pass(113, 1'b0, 3000);
        chk("pass1_err", 32'(Err), 32'd0);
        chk("pass1_addr_hold", 32'(Addr), 32'd15);
        chk("pass1_word14", 32'(ram[14]), 32'd15);

        // Root unit never answers word 5
        preload();
        hang_addr = 5;
        run_pass(174, 1'b0, 3000);
        hang_addr = -1;
        chk("hang_err", 32'(Err), 32'd1);
        chk("hang_word5", 32'(ram[5]), 32'hFF);

        // Roots of roots with a stray St during WAIT of word 3
        run_pass(113, 1'b1, 3000);
        chk("pulse_err", 32'(Err), 32'd0);
        chk("pulse_word5", 32'(ram[5]), 32'd15);

        // Done held high from before the pass: every word times out
        hold_high = 1'b1;
        Root_Done = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        run_pass(1089, 1'b0, 3000);
        chk("hold_err", 32'(Err), 32'd1);
        hold_high = 1'b0;
        Root_Done = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset asserted during WR of word 7
        preload();
        push_expect(7);
        w   = init_tbl[7];
        cyc = 0;
        hit = 1'b0;
        St  = 1'b1;
        while (cyc < 500) begin
            @(posedge CLK); #1;
            cyc++;
            if (cyc == 1) St = 1'b0;
            if (Write_Enable && Addr == 4'd7) begin
                hit = 1'b1;
                break;
            end
            if (Write_Enable) check_write();
        end
        chk("rst_reached_wr7", 32'(hit), 32'd1);
        ResetN = 1'b0;
        #1;
        chk("midrst_we", 32'(Write_Enable), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_addr", 32'(Addr), 32'd0);
        chk("midrst_root_st", 32'(Root_St), 32'd0);
        chk("midrst_done", 32'(Done), 32'd0);
        chk("midrst_mdi", 32'(MDI), 32'd0);
        chk("midrst_err", 32'(Err), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        ResetN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("post_rst_busy", 32'(Busy), 32'd0);
        chk("post_rst_addr", 32'(Addr), 32'd0);
        chk("post_rst_we", 32'(Write_Enable), 32'd0);
        chk("post_rst_sb", 32'(exp_q.size()), 32'd0);
        chk("post_rst_word7", 32'(ram[7]), 32'(w));
        for (int a = 0; a < 16; a++) chk("post_rst_ram", 32'(ram[a]), 32'(exp_mem[a]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
